fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares one single-port 160x120x12 framebuffer RAM between the display pixel fetch (VGA side, read-only) and the camera/pixel writer (write-only).
- Display reads have priority. Writes are posted into a small FIFO and drained in idle cycles.
- A starvation counter guarantees write progress under continuous display reads.
- Sits between the VGA driver address path, the capture block and the framebuffer RAM (synchronous read, 1-cycle latency).

Parameters:
- DW, 12, pixel width (RGB444)
- AW, 15, RAM address width
- MEM_WORDS, 19200, valid RAM words (160*120)
- FIFO_DEPTH, 4, posted-write FIFO entries (power of 2)
- STARVE_MAX, 8, consecutive denied-write cycles before a forced write slot

Ports:
- clk, in, 1, system clock (25 MHz pixel clock)
- rst_n, in, 1, asynchronous active-low reset
- rd_req, in, 1, display read request; held with rd_addr until granted
- rd_addr, in, AW, display read address (y*160+x)
- rd_gnt, out, 1, read accepted this cycle (combinational)
- rd_valid, out, 1, rd_data valid
- rd_data, out, DW, read pixel
- wr_req, in, 1, write request
- wr_addr, in, AW, write address
- wr_data, in, DW, write pixel
- wr_ready, out, 1, FIFO can accept; transfer when wr_req&&wr_ready
- mem_en, out, 1, RAM enable (registered)
- mem_we, out, 1, RAM write enable (registered)
- mem_addr, out, AW, RAM address (registered)
- mem_wdata, out, DW, RAM write data (registered)
- mem_rdata, in, DW, RAM read data, valid 1 cycle after mem_en&&!mem_we
- forced_wr, out, 1, pulse: this cycle's slot was a forced write (debug)

Behaviour:
- Reset (rst_n low, async): mem_en/mem_we/mem_addr/mem_wdata=0, rd_valid=0, forced_wr=0, FIFO emptied, starve_cnt=0, read pipeline valid bits cleared, wr_ready=0 while rst_n low. wr_ready=1 from the first clk edge after release.
- Slot decision each cycle, combinational, priority order:
  - force_wr = (starve_cnt==STARVE_MAX) && fifo_not_empty
  - force_wr -> issue FIFO head write, rd_gnt=0
  - else rd_req -> rd_gnt=1, issue read
  - else fifo_not_empty -> issue write
  - else idle (mem_en=0 next cycle)
- Issue timing: decision in cycle t registers onto mem_* in t+1. For reads, rd_valid=1 in t+2 with rd_data=mem_rdata. rd_data is don't-care when rd_valid=0. Back-to-back reads give one rd_valid per grant, in order.
- starve_cnt: increments (saturating at STARVE_MAX) in each cycle where the FIFO is non-empty and no write is issued. Cleared on any write issue or when the FIFO is empty. forced_wr=1 in the cycle force_wr is taken.
- FIFO: wr_ready = !full. Push on wr_req&&wr_ready, pop on write issue. Push and pop in the same cycle are legal; the level is unchanged. No bypass: an accepted write reaches mem_* no earlier than 2 cycles after acceptance. Strict FIFO order.
- Out of range writes (wr_addr >= MEM_WORDS): accepted (handshake completes) and discarded, never pushed.
- Out of range reads (rd_addr >= MEM_WORDS): granted normally, but mem_en stays 0 for that slot. rd_valid still asserts at t+2 with rd_data forced to 0.
- Same-address hazard: a read granted while a write to the same address sits in the FIFO returns the old RAM content. This is intended behaviour, not checked.
- Reset mid-operation: queued writes lost, in-flight read produces no rd_valid.
- Widths: FIFO level counter is log2(FIFO_DEPTH)+1 bits. starve_cnt is clog2(STARVE_MAX+1) bits.

Decomposition:
- Package fb_pkg holds:
  - SCREEN_X=160, SCREEN_Y=120, MEM_WORDS, DW, AW
  - slot enum {SLOT_IDLE, SLOT_RD, SLOT_WR, SLOT_FWR}
- Sub-module fb_wr_fifo: parameterised DW+AW wide, FIFO_DEPTH entries, async active-low reset. Ports: push, pop, full, empty, head data/address.
- Arbitration, starve counter and output registers stay in fb_port_arbiter.

Test Plan:
- Reset: rst_n=0 mid-traffic -> all mem_* and rd_valid 0 immediately, wr_ready=0. Release -> wr_ready=1 next edge, no stale rd_valid.
- Single read: RAM[100]=12'hABC, rd_req at t with rd_addr=100 -> rd_gnt=1 at t. At t+1 mem_en=1, mem_we=0, mem_addr=100. At t+2 rd_valid=1, rd_data=12'hABC.
- Idle write then read: write (5, 12'h123) accepted at t -> mem_we=1, mem_addr=5, mem_wdata=12'h123 at t+2. A later read of 5 returns 12'h123.
- Starvation: queue 4 writes, hold rd_req=1 continuously -> wr_ready=0. After 8 denied cycles, exactly 1 cycle with rd_gnt=0 and forced_wr=1. Pattern repeats every 9 cycles until the FIFO drains; writes land in order.
- Full FIFO backpressure: 6 writes presented back-to-back under continuous reads -> 5th and 6th stall with wr_ready=0 and are accepted as slots free. All 6 written, none lost or duplicated.
- Out of range: write addr 19200 -> accepted, never appears on mem_we. Read addr 19200 -> mem_en=0 at t+1, rd_valid=1 with rd_data=0 at t+2.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer port arbiter.
// Screen geometry, default widths and the per-cycle slot decision encoding.
package fb_pkg;
  localparam int SCREEN_X  = 160;
  localparam int SCREEN_Y  = 120;
  localparam int MEM_WORDS = SCREEN_X * SCREEN_Y;
  localparam int DW        = 12;
  localparam int AW        = 15;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_RD, SLOT_WR, SLOT_FWR} slot_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// Posted-write FIFO: holds {address, pixel} pairs until the arbiter finds a slot.
// No bypass path; the head is only visible the cycle after a push.
module fb_wr_fifo #(
  parameter int DW    = 12,
  parameter int AW    = 15,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] store [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      level;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (PW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign {head_addr, head_data} = store[rptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wptr] <= {push_addr, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display reads win, camera writes are posted
// and drained in idle slots, with a starvation counter forcing write progress.
module fb_port_arbiter #(
  parameter int DW         = fb_pkg::DW,
  parameter int AW         = fb_pkg::AW,
  parameter int MEM_WORDS  = fb_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          forced_wr
);
  import fb_pkg::*;

  localparam int            SW    = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] LIMIT = AW'(MEM_WORDS);

  logic          ready_q;
  logic          full;
  logic          empty;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [SW-1:0] starve_cnt;
  logic          force_wr;
  logic          issue_wr;
  logic          rd_oor;
  logic          push;
  logic          rd_p1;
  logic          rd_p1_oor;
  logic          rd_zero;
  slot_t         slot;

  // Out-of-range writes still complete the handshake but are never queued.
  assign wr_ready = ready_q && !full;
  assign push     = wr_req && wr_ready && (wr_addr < LIMIT);
  assign rd_oor   = (rd_addr >= LIMIT);
  assign force_wr = (starve_cnt == SW'(STARVE_MAX)) && !empty;

  always_comb begin
    slot = SLOT_IDLE;
    if (force_wr)    slot = SLOT_FWR;
    else if (rd_req) slot = SLOT_RD;
    else if (!empty) slot = SLOT_WR;
  end

  assign issue_wr  = (slot == SLOT_WR) || (slot == SLOT_FWR);
  assign rd_gnt    = (slot == SLOT_RD);
  assign forced_wr = (slot == SLOT_FWR);

  fb_wr_fifo #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (issue_wr),
    .full      (full),
    .empty     (empty),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_p1      <= 1'b0;
      rd_p1_oor  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_zero    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      ready_q <= 1'b1;
      mem_en  <= issue_wr || (rd_gnt && !rd_oor);
      mem_we  <= issue_wr;
      if (issue_wr) begin
        mem_addr  <= head_addr;
        mem_wdata <= head_data;
      end else if (rd_gnt) begin
        mem_addr  <= rd_addr;
      end
      // Out-of-range reads keep their pipeline slot so rd_valid ordering holds.
      rd_p1     <= rd_gnt;
      rd_p1_oor <= rd_gnt && rd_oor;
      rd_valid  <= rd_p1;
      rd_zero   <= rd_p1_oor;
      if (empty || issue_wr)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign rd_data = rd_zero ? '0 : mem_rdata;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural synchronous RAM.
// Vector table for single-cycle behaviour, hand sequences for multi-cycle cases.
module tb_fb_port_arbiter;
  localparam int DW = 12;
  localparam int AW = 15;
  localparam int MW = 19200;
  localparam int NV = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          forced_wr;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0]    ram [MW];
  logic [AW+DW-1:0] wq [$];

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .DW         (DW),
    .AW         (AW),
    .MEM_WORDS  (MW),
    .FIFO_DEPTH (4),
    .STARVE_MAX (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .forced_wr (forced_wr)
  );

  // Behavioural single-port RAM, 1-cycle read latency; preloads happen at time 0.
  initial begin
    ram[100]   = 12'hABC;
    ram[200]   = 12'h5A5;
    ram[19199] = 12'h777;
    forever begin
      @(posedge clk);
      if (mem_en && (int'(mem_addr) < MW)) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        else        mem_rdata = ram[mem_addr];
      end
    end
  end

  always @(negedge clk)
    if (rst_n && mem_en && mem_we) wq.push_back({mem_addr, mem_wdata});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic          rq;
    logic [AW-1:0] ra;
    logic          wrq;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          gnt;
    logic          rdy;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          vld;
    logic [DW-1:0] rdata;
  } vec_t;

  function automatic vec_t mk(logic rq, int ra, logic wrq, int wa, int wd,
                              logic gnt, logic en, logic we, int addr, int wdata,
                              logic vld, int rdata);
    vec_t v;
    v.rq = rq;   v.ra = AW'(ra);   v.wrq = wrq; v.wa = AW'(wa); v.wd = DW'(wd);
    v.gnt = gnt; v.rdy = 1'b1;     v.en = en;   v.we = we;
    v.addr = AW'(addr); v.wdata = DW'(wdata); v.vld = vld; v.rdata = DW'(rdata);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_en"},    32'(mem_en),    32'(0));
    check({tag, "_mem_we"},    32'(mem_we),    32'(0));
    check({tag, "_mem_addr"},  32'(mem_addr),  32'(0));
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    check({tag, "_rd_valid"},  32'(rd_valid),  32'(0));
    check({tag, "_wr_ready"},  32'(wr_ready),  32'(0));
    check({tag, "_forced"},    32'(forced_wr), 32'(0));
  endtask

  vec_t vt [NV];

  initial begin
    int j;
    int stall [6];
    logic ef;

    //                rq  ra     wrq wa     wd      gnt en we addr   wdata  vld rdata
    vt[0]  = mk(1, 100,   0, 0,     0,      1, 0, 0, 0,     0,      0, 0);
    vt[1]  = mk(0, 0,     0, 0,     0,      0, 1, 0, 100,   0,      0, 0);
    vt[2]  = mk(0, 0,     0, 0,     0,      0, 0, 0, 0,     0,      1, 'hABC);
    vt[3]  = mk(0, 0,     1, 5,     'h123,  0, 0, 0, 0,     0,      0, 0);
    vt[4]  = mk(0, 0,     0, 0,     0,      0, 0, 0, 0,     0,      0, 0);
    vt[5]  = mk(0, 0,     0, 0,     0,      0, 1, 1, 5,     'h123,  0, 0);
    vt[6]  = mk(1, 5,     0, 0,     0,      1, 0, 0, 0,     0,      0, 0);
    vt[7]  = mk(1, 19200, 0, 0,     0,      1, 1, 0, 5,     0,      0, 0);
    vt[8]  = mk(1, 19199, 0, 0,     0,      1, 0, 0, 0,     0,      1, 'h123);
    vt[9]  = mk(0, 0,     1, 19200, 'hFFF,  0, 1, 0, 19199, 0,      1, 0);
    vt[10] = mk(0, 0,     0, 0,     0,      0, 0, 0, 0,     0,      1, 'h777);
    vt[11] = mk(0, 0,     0, 0,     0,      0, 0, 0, 0,     0,      0, 0);
    vt[12] = mk(0, 0,     0, 0,     0,      0, 0, 0, 0,     0,      0, 0);
    vt[13] = mk(1, 200,   1, 7,     'h0F0,  1, 0, 0, 0,     0,      0, 0);
    vt[14] = mk(0, 0,     0, 0,     0,      0, 1, 0, 200,   0,      0, 0);
    vt[15] = mk(0, 0,     0, 0,     0,      0, 1, 1, 7,     'h0F0,  1, 'h5A5);
    vt[16] = mk(0, 0,     0, 0,     0,      0, 0, 0, 0,     0,      0, 0);

    // Power-on reset
    #3;
    check_reset_state("por");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("por_rdy_before_edge", 32'(wr_ready), 32'(0));
    tick;
    check("por_rdy_after_edge", 32'(wr_ready), 32'(1));
    repeat (3) tick;

    // Table-driven single-cycle behaviour
    wq.delete();
    for (int i = 0; i < NV; i++) begin
      tick;
      rd_req = vt[i].rq; rd_addr = vt[i].ra;
      wr_req = vt[i].wrq; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      #1;
      check($sformatf("v%0d_gnt", i),    32'(rd_gnt),    32'(vt[i].gnt));
      check($sformatf("v%0d_rdy", i),    32'(wr_ready),  32'(vt[i].rdy));
      check($sformatf("v%0d_forced", i), 32'(forced_wr), 32'(0));
      check($sformatf("v%0d_en", i),     32'(mem_en),    32'(vt[i].en));
      check($sformatf("v%0d_we", i),     32'(mem_we),    32'(vt[i].we));
      check($sformatf("v%0d_vld", i),    32'(rd_valid),  32'(vt[i].vld));
      if (vt[i].en) check($sformatf("v%0d_addr", i),  32'(mem_addr),  32'(vt[i].addr));
      if (vt[i].we) check($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vt[i].wdata));
      if (vt[i].vld) check($sformatf("v%0d_rdata", i), 32'(rd_data), 32'(vt[i].rdata));
    end
    idle_inputs();
    repeat (3) tick;
    check("vec_write_count", 32'(wq.size()), 32'(2));
    if (wq.size() == 2) begin
      check("vec_write0", 32'(wq[0]), 32'({15'd5, 12'h123}));
      check("vec_write1", 32'(wq[1]), 32'({15'd7, 12'h0F0}));
    end

    // Starvation: 4 queued writes under continuous reads -> forced slot every 9 cycles
    wq.delete();
    for (int i = 0; i < 45; i++) begin
      tick;
      rd_req = 1'b1; rd_addr = AW'(100);
      if (i < 4) begin
        wr_req = 1'b1; wr_addr = AW'(1000 + i); wr_data = DW'(12'h101 + i);
      end else begin
        wr_req = 1'b0;
      end
      #1;
      ef = (i == 9) || (i == 18) || (i == 27) || (i == 36);
      check($sformatf("stv%0d_forced", i), 32'(forced_wr), 32'(ef));
      check($sformatf("stv%0d_gnt", i),    32'(rd_gnt),    32'(!ef));
      check($sformatf("stv%0d_rdy", i),    32'(wr_ready),  32'((i < 4) || (i >= 10)));
    end
    idle_inputs();
    repeat (4) tick;
    check("stv_write_count", 32'(wq.size()), 32'(4));
    for (int k = 0; k < 4; k++)
      if (k < wq.size())
        check($sformatf("stv_write%0d", k), 32'(wq[k]),
              32'({AW'(1000 + k), DW'(12'h101 + k)}));

    // Backpressure: 6 back-to-back writes under continuous reads
    wq.delete();
    j = 0;
    for (int k = 0; k < 6; k++) stall[k] = 0;
    for (int i = 0; i < 70; i++) begin
      tick;
      rd_req = 1'b1; rd_addr = AW'(300);
      if (j < 6) begin
        wr_req = 1'b1; wr_addr = AW'(2000 + j); wr_data = DW'(12'h201 + j);
      end else begin
        wr_req = 1'b0;
      end
      #1;
      if (j < 6) begin
        if (wr_ready) j++;
        else          stall[j]++;
      end
    end
    idle_inputs();
    repeat (4) tick;
    check("bp_accepted", 32'(j), 32'(6));
    check("bp_stall0", 32'(stall[0]), 32'(0));
    check("bp_stall3", 32'(stall[3]), 32'(0));
    check("bp_stall4", 32'(stall[4]), 32'(6));
    check("bp_stall5", 32'(stall[5]), 32'(8));
    check("bp_write_count", 32'(wq.size()), 32'(6));
    for (int k = 0; k < 6; k++)
      if (k < wq.size())
        check($sformatf("bp_write%0d", k), 32'(wq[k]),
              32'({AW'(2000 + k), DW'(12'h201 + k)}));

    // Reset mid-traffic: queued writes and in-flight reads vanish
    wq.delete();
    tick;
    rd_req = 1'b1; rd_addr = AW'(100);
    wr_req = 1'b1; wr_addr = AW'(3000); wr_data = 12'h333;
    tick;
    rd_addr = AW'(200);
    wr_addr = AW'(3001); wr_data = 12'h334;
    tick;
    idle_inputs();
    #1 check("mid_mem_en_busy", 32'(mem_en), 32'(1));
    #1 rst_n = 1'b0;
    #1 check_reset_state("mid");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("mid_rdy_before_edge", 32'(wr_ready), 32'(0));
    tick;
    check("mid_rdy_after_edge", 32'(wr_ready), 32'(1));
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("post%0d_en", i),  32'(mem_en),   32'(0));
      check($sformatf("post%0d_vld", i), 32'(rd_valid), 32'(0));
    end
    check("post_write_count", 32'(wq.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
